// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_pkg                                                      |
// | Description : Shared AES types, constants and composite-field arithmetic.  |
// |               GF(2^8) is modelled as GF(((2^2)^2)^2):                      |
// |                 GF(4)   = GF(2)[w]/(w^2+w+1)                               |
// |                 GF(16)  = GF(4)[y]/(y^2+y+N),   N  = w                     |
// |                 GF(256) = GF(16)[z]/(z^2+z+mu), mu = w^2*y + w             |
// |               Tower byte layout: [7:4] z-coefficient, [3:0] constant;      |
// |               nibble [3:2] y-coefficient; pair [1] w-coefficient.          |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    INV_SB_IDLE = 2'd0,
    INV_SB_RUN  = 2'd1,
    INV_SB_DONE = 2'd2
  } inv_sb_state_e;

  localparam aes_byte_t  AES_AFFINE_C     = 8'h63;
  localparam aes_byte_t  AES_INV_AFFINE_C = 8'h05;
  localparam logic [1:0] GF_N             = 2'b10;
  localparam logic [3:0] GF_MU            = 4'b1110;

  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic hh;
    hh = a[1] & b[1];
    return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
  endfunction

  // Squaring in GF(4) is linear; a^2 is also a^-1 for non-zero a.
  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    hh = gf4_mul(a[3:2], b[3:2]);
    return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
            gf4_mul(hh, GF_N) ^ gf4_mul(a[1:0], b[1:0])};
  endfunction

  // (a1*y + a0)^-1 = (a1*y + (a1+a0)) / (a1^2*N + a1*a0 + a0^2); 0 maps to 0.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [1:0] d;
    logic [1:0] di;
    d  = gf4_mul(gf4_sq(a[3:2]), GF_N) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
    di = gf4_sq(d);
    return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
  endfunction

  function automatic aes_byte_t gf256_mul(input aes_byte_t a, input aes_byte_t b);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(hh, GF_MU) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  // Linear map: column i (bits [8i+7:8i]) is the image of bit i.
  function automatic aes_byte_t aes_iso_apply(input logic [63:0] m, input aes_byte_t a);
    aes_byte_t r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) r = r ^ m[8*i +: 8];
    end
    return r;
  endfunction

  // AES basis -> tower basis: pick a tower root beta of x^8+x^4+x^3+x+1 and
  // map x^i to beta^i. Evaluated once at elaboration.
  function automatic logic [63:0] aes_iso_build_fwd();
    logic [63:0] m;
    aes_byte_t   beta, cb, t2, t3, t4, t8, col;
    logic        found;
    int          c;
    beta  = 8'h02;
    found = 1'b0;
    c     = 2;
    while (!found && c < 256) begin
      cb = 8'(c);
      t2 = gf256_mul(cb, cb);
      t3 = gf256_mul(t2, cb);
      t4 = gf256_mul(t2, t2);
      t8 = gf256_mul(t4, t4);
      if ((t8 ^ t4 ^ t3 ^ cb ^ 8'h01) == 8'h00) begin
        beta  = cb;
        found = 1'b1;
      end
      c = c + 1;
    end
    m   = '0;
    col = 8'h01;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = col;
      col         = gf256_mul(col, beta);
    end
    return m;
  endfunction

  // Tower basis -> AES basis: column j is the preimage of tower bit j.
  function automatic logic [63:0] aes_iso_build_inv(input logic [63:0] fwd);
    logic [63:0] m;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      for (int a = 0; a < 256; a++) begin
        if (aes_iso_apply(fwd, 8'(a)) == (8'h01 << j)) m[8*j +: 8] = 8'(a);
      end
    end
    return m;
  endfunction

  localparam logic [63:0] AES_ISO_FWD = aes_iso_build_fwd();
  localparam logic [63:0] AES_ISO_INV = aes_iso_build_inv(AES_ISO_FWD);

endpackage
`default_nettype wire

// File: rtl/aes_gf_inv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_gf_inv                                                   |
// | Description : Combinational GF(((2^2)^2)^2) inverter, tower basis in/out.  |
// |               Zero maps to zero.                                           |
// | Ports       : a_i   [7:0] operand (tower basis)                            |
// |               inv_o [7:0] multiplicative inverse (tower basis)             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_gf_inv
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] inv_o
);

  logic [3:0] ah;
  logic [3:0] al;
  logic [3:0] d;
  logic [3:0] d_inv;

  assign ah = a_i[7:4];
  assign al = a_i[3:0];

  // (ah*z + al)^-1 = (ah*z + (ah+al)) / (ah^2*mu + ah*al + al^2)
  assign d     = gf16_mul(gf16_mul(ah, ah), GF_MU) ^ gf16_mul(ah, al) ^ gf16_mul(al, al);
  assign d_inv = gf16_inv(d);
  assign inv_o = {gf16_mul(ah, d_inv), gf16_mul(ah ^ al, d_inv)};

endmodule
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_inv_sbox                                                 |
// | Description : Combinational AES inverse S-box: inverse affine transform,   |
// |               then composite-field inversion between isomorphism maps.     |
// | Ports       : byte_i [7:0] input byte                                      |
// |               byte_o [7:0] inv_sbox(byte_i)                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  aes_byte_t inv_aff;
  aes_byte_t tower_in;
  aes_byte_t tower_inv;

  always_comb begin
    inv_aff = '0;
    for (int i = 0; i < 8; i++) begin
      inv_aff[i] = byte_i[(i + 2) % 8] ^ byte_i[(i + 5) % 8] ^ byte_i[(i + 7) % 8]
                 ^ AES_INV_AFFINE_C[i];
    end
  end

  assign tower_in = aes_iso_apply(AES_ISO_FWD, inv_aff);

  aes_gf_inv u_gf_inv (
    .a_i   (tower_in),
    .inv_o (tower_inv)
  );

  assign byte_o = aes_iso_apply(AES_ISO_INV, tower_inv);

endmodule
`default_nettype wire

// File: rtl/aes_inv_subbytes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_inv_subbytes                                             |
// | Description : Byte-serial AES InvSubBytes engine. Loads a 128-bit state,   |
// |               substitutes BYTES_PER_CYCLE bytes per clock in place, then   |
// |               presents the result until the consumer takes it.             |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               in_valid/in_ready/in_state[127:0]    input handshake         |
// |               out_valid/out_ready/out_state[127:0] output handshake        |
// |               busy                                 high in RUN or DONE     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_inv_subbytes
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int STEPS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_cfg
    $error("aes_inv_subbytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  inv_sb_state_e                         state_q;
  logic [CNT_W-1:0]                      cnt_q;
  aes_state_t                            data_q;
  aes_state_t                            data_d;
  logic [3:0]                            base;
  logic [BYTES_PER_CYCLE-1:0][7:0]       lane_in;
  logic [BYTES_PER_CYCLE-1:0][7:0]       lane_out;

  // Index of the first byte handled this step.
  assign base = 4'(int'(cnt_q) * BYTES_PER_CYCLE);

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    assign lane_in[l] = data_q[{base + 4'(l), 3'b000} +: 8];

    aes_inv_sbox u_inv_sbox (
      .byte_i (lane_in[l]),
      .byte_o (lane_out[l])
    );
  end

  always_comb begin
    data_d = data_q;
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      data_d[{base + 4'(l), 3'b000} +: 8] = lane_out[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INV_SB_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        INV_SB_IDLE: begin
          if (in_valid) begin
            data_q  <= in_state;
            cnt_q   <= '0;
            state_q <= INV_SB_RUN;
          end
        end
        INV_SB_RUN: begin
          data_q <= data_d;
          // Counter parks on the last step rather than wrapping.
          if (cnt_q == LAST_STEP) begin
            state_q <= INV_SB_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        INV_SB_DONE: begin
          if (out_ready) state_q <= INV_SB_IDLE;
        end
        default: state_q <= INV_SB_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == INV_SB_IDLE);
  assign out_valid = (state_q == INV_SB_DONE);
  assign busy      = (state_q != INV_SB_IDLE);
  assign out_state = data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_subbytes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_aes_inv_subbytes                                          |
// | Description : Directed self-checking bench for aes_inv_subbytes with       |
// |               instances at BYTES_PER_CYCLE = 1, 4 and 16.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_aes_inv_subbytes;

  localparam logic [127:0] ZERO_EXP  = {16{8'h52}};
  localparam logic [127:0] KNOWN_IN  = 128'h16636363_63ED6363_63637C63_63636363;
  localparam logic [127:0] KNOWN_EXP = 128'hFF000000_00530000_00000100_00000000;

  logic               clk;
  logic               rst_n;
  logic [127:0]       in_state;
  logic [2:0]         in_valid_v;
  logic [2:0]         in_ready_v;
  logic [2:0]         out_valid_v;
  logic [2:0]         out_ready_v;
  logic [2:0]         busy_v;
  logic [2:0][127:0]  out_state_v;

  int                 n_checks;
  int                 n_pass;
  logic [7:0]         sbox_tab [256];
  int                 lat_tab  [3];

  aes_inv_subbytes #(.BYTES_PER_CYCLE(1)) u_dut_b1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_state(in_state), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_state(out_state_v[0]), .busy(busy_v[0]));

  aes_inv_subbytes #(.BYTES_PER_CYCLE(4)) u_dut_b4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_state(in_state), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_state(out_state_v[1]), .busy(busy_v[1]));

  aes_inv_subbytes #(.BYTES_PER_CYCLE(16)) u_dut_b16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_state(in_state), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_state(out_state_v[2]), .busy(busy_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Polynomial-basis AES arithmetic, independent of the tower-field design.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] r, p, b;
    r = 8'h01; p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic accept(input int idx, input logic [127:0] st);
    int waited;
    waited = 0;
    while (!in_ready_v[idx] && waited < 50) begin
      tick();
      waited++;
    end
    chk($sformatf("accept_ready_u%0d", idx), in_ready_v[idx], 1);
    in_state        = st;
    in_valid_v[idx] = 1'b1;
    tick();
    in_valid_v[idx] = 1'b0;
    in_state        = ~st;
  endtask

  task automatic collect(input int idx, input int exp_lat, output logic [127:0] res);
    int lat;
    lat = 0;
    while (!out_valid_v[idx] && lat < 40) begin
      tick();
      lat++;
    end
    chk($sformatf("latency_u%0d", idx), lat, exp_lat);
    res = out_state_v[idx];
  endtask

  initial begin
    logic [127:0] st;
    logic [127:0] res;
    logic [127:0] fwd;
    int           seen;

    n_checks = 0;
    n_pass   = 0;
    lat_tab  = '{16, 4, 1};
    for (int v = 0; v < 256; v++) sbox_tab[v] = fwd_sbox(8'(v));

    rst_n       = 1'b1;
    in_valid_v  = 3'b000;
    out_ready_v = 3'b111;
    in_state    = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",   in_ready_v[1],  1);
    chk("rst_out_valid",  out_valid_v[1], 0);
    chk("rst_busy",       busy_v[1],      0);
    chk("rst_out_state",  out_state_v[1], 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready",  in_ready_v,     3'b111);

    accept(1, '0);
    collect(1, 4, res);
    chk("zero_state", res, ZERO_EXP);
    tick();
    chk("post_hs_valid", out_valid_v[1], 0);
    chk("post_hs_ready", in_ready_v[1],  1);

    accept(1, KNOWN_IN);
    collect(1, 4, res);
    chk("known_bytes", res, KNOWN_EXP);

    for (int u = 0; u < 3; u++) begin
      for (int j = 0; j < 16; j++) begin
        for (int i = 0; i < 16; i++) st[8*i +: 8] = 8'(16*j + i);
        accept(u, st);
        collect(u, lat_tab[u], res);
        for (int i = 0; i < 16; i++) fwd[8*i +: 8] = sbox_tab[res[8*i +: 8]];
        chk($sformatf("sweep_u%0d_s%0d", u, j), fwd, st);
      end
    end

    // Backpressure: hold DONE, pulse in_valid, then release with in_valid high.
    tick();
    out_ready_v[1] = 1'b0;
    accept(1, KNOWN_IN);
    collect(1, 4, res);
    for (int c = 0; c < 5; c++) begin
      in_valid_v[1] = c[0];
      in_state      = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("bp_out_state", out_state_v[1], KNOWN_EXP);
      chk("bp_out_valid", out_valid_v[1], 1);
      chk("bp_in_ready",  in_ready_v[1],  0);
    end
    in_state       = '0;
    in_valid_v[1]  = 1'b1;
    out_ready_v[1] = 1'b1;
    tick();
    chk("bp_release_valid", out_valid_v[1], 0);
    chk("bp_release_ready", in_ready_v[1],  1);
    chk("bp_release_busy",  busy_v[1],      0);
    tick();
    in_valid_v[1] = 1'b0;
    in_state      = {4{32'hDEADBEEF}};
    chk("bp_next_accept_busy", busy_v[1], 1);
    collect(1, 4, res);
    chk("bp_next_state", res, ZERO_EXP);

    // Reset during the second RUN cycle.
    accept(1, KNOWN_IN);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  in_ready_v[1],  1);
    chk("mid_rst_out_valid", out_valid_v[1], 0);
    chk("mid_rst_busy",      busy_v[1],      0);
    chk("mid_rst_out_state", out_state_v[1], 0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen  = 0;
    repeat (6) begin
      tick();
      if (out_valid_v[1]) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);
    accept(1, '0);
    collect(1, 4, res);
    chk("mid_rst_next_state", res, ZERO_EXP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
